multdiv_ctrl: RTL and testbench

Sequencer for the iterative multiply/divide unit. Accepts a single-cycle start from the pipeline (`ctrl_MULT` / `ctrl_DIV`) and drives the multdiv datapath's control strobes:
- operand load
- per-iteration step
- divide correction

It counts iterations with a 6-bit iteration counter. It reports completion with a one-cycle `data_resultRDY` pulse, plus `data_exception` for divide-by-zero or multiply overflow.

---
 rtl/multdiv_ctrl_pkg.sv | 21 ++
 rtl/multdiv_ctrl_if.sv | 31 +++
 rtl/multdiv_ctrl_iter_count.sv | 33 +++
 rtl/multdiv_ctrl.sv | 99 +++++++++
 tb/tb_multdiv_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// default iteration counts and the iteration counter width.
package multdiv_pkg;

  localparam int CNT_W          = 6;
  localparam int MULT_ITERS_DEF = 16;
  localparam int DIV_ITERS_DEF  = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // Counter value seen in the final step cycle of an operation of `iters` steps.
  function automatic logic [CNT_W-1:0] last_iter(input int iters);
    return CNT_W'(iters - 1);
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Pipeline-side start/flag signals and datapath control strobes of the
// multiply/divide sequencer.
interface multdiv_ctrl_if;
  import multdiv_pkg::*;

  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic             divisor_zero;
  logic             mult_ovf;
  logic             load_en;
  logic             step_en;
  logic             fix_en;
  logic             op_div;
  logic [CNT_W-1:0] iter_count;
  logic             busy;
  logic             data_resultRDY;
  logic             data_exception;

  modport master (
    output ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
    input  load_en, step_en, fix_en, op_div, iter_count, busy,
           data_resultRDY, data_exception
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, divisor_zero, mult_ovf,
    output load_en, step_en, fix_en, op_div, iter_count, busy,
           data_resultRDY, data_exception
  );

endinterface

// File: rtl/multdiv_ctrl_iter_count.sv
// Iteration counter: synchronous up-counter built from per-bit toggle
// enables, with a synchronous clear that overrides the enable.
module iter_count_6
  import multdiv_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d, tog;

  // Bit i toggles when enabled and every lower bit is one.
  always_comb begin
    tog[0] = en;
    for (int i = 1; i < CNT_W; i++) begin
      tog[i] = tog[i-1] & cnt_q[i-1];
    end
    cnt_d = cnt_q ^ tog;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: loads operands,
// steps the iterations, applies the divide correction and flags completion.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_ITERS = MULT_ITERS_DEF,
  parameter int DIV_ITERS  = DIV_ITERS_DEF
) (
  input  logic          clk,
  input  logic          clr,
  multdiv_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MULT_LAST = last_iter(MULT_ITERS);
  localparam logic [CNT_W-1:0] DIV_LAST  = last_iter(DIV_ITERS);

  state_t           state_q, state_d;
  logic             op_div_q, op_div_d;
  logic             div0_q, div0_d;
  logic             start, is_div_start, terminal;
  logic             cnt_en, cnt_clr;
  logic             step, fix, rdy, exc;
  logic [CNT_W-1:0] cnt_val;

  assign start        = (bus.ctrl_MULT | bus.ctrl_DIV) & ~clr;
  assign is_div_start = bus.ctrl_DIV & ~bus.ctrl_MULT;
  assign terminal     = cnt_val == (op_div_q ? DIV_LAST : MULT_LAST);
  assign cnt_clr      = clr | start;

  iter_count_6 u_iter_count (
    .clk   (clk),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_val)
  );

  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    div0_d   = div0_q;
    cnt_en   = 1'b0;
    step     = 1'b0;
    fix      = 1'b0;
    rdy      = 1'b0;
    exc      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        step = 1'b1;
        if (terminal) begin
          state_d = op_div_q ? S_FIX : S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_FIX: begin
        fix     = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        rdy     = 1'b1;
        exc     = div0_q | (~op_div_q & bus.mult_ovf);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new start pre-empts whatever the current state would do next.
    if (start) begin
      op_div_d = is_div_start;
      div0_d   = is_div_start & bus.divisor_zero;
      state_d  = div0_d ? S_DONE : S_RUN;
      cnt_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      op_div_q <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      div0_q   <= div0_d;
    end
  end

  // Every output reads as zero while clr is held.
  assign bus.load_en        = start;
  assign bus.step_en        = step & ~clr;
  assign bus.fix_en         = fix & ~clr;
  assign bus.data_resultRDY = rdy & ~clr;
  assign bus.data_exception = exc & ~clr;
  assign bus.op_div         = op_div_q & ~clr;
  assign bus.iter_count     = clr ? '0 : cnt_val;
  assign bus.busy           = ((state_q != S_IDLE) | start) & ~clr;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: table-driven single operations plus
// abort, reset and back-to-back sequences, with a result scoreboard.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  typedef struct {
    string name;
    logic  isMult;
    logic  isDiv;
    logic  dz;
    logic  ovf;
    int    steps;
    int    fixCycle;
    int    rdyCycle;
    logic  expExc;
    logic  expOpDiv;
  } vec_t;

  typedef struct {
    int   cycle;
    logic exc;
    logic opDiv;
  } exp_t;

  logic  clk = 1'b0;
  logic  clr;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string curName = "reset";
  exp_t  sb[$];
  vec_t  vecs[8];

  always #5 clk = ~clk;

  multdiv_ctrl_if bus ();

  multdiv_ctrl #(
    .MULT_ITERS (16),
    .DIV_ITERS  (32)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  function automatic vec_t mkVec(input string n, input logic m, input logic d,
                                 input logic z, input logic o, input int s,
                                 input int f, input int r, input logic e,
                                 input logic od);
    vec_t v;
    v.name = n; v.isMult = m; v.isDiv = d; v.dz = z; v.ovf = o;
    v.steps = s; v.fixCycle = f; v.rdyCycle = r; v.expExc = e; v.expOpDiv = od;
    return v;
  endfunction

  function automatic logic [12:0] allOutputs();
    return {bus.load_en, bus.step_en, bus.fix_en, bus.op_div, bus.iter_count,
            bus.busy, bus.data_resultRDY, bus.data_exception};
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s/%s at cycle %0d: got 0x%0h, expected 0x%0h",
               curName, what, cyc, act, exp);
    end
  endtask

  task automatic pushExpect(input int c, input logic e, input logic od);
    exp_t x;
    x.cycle = c; x.exc = e; x.opDiv = od;
    sb.push_back(x);
  endtask

  task automatic scoreboardCheck();
    exp_t x;
    if (sb.size() > 0 && sb[0].cycle == cyc) begin
      x = sb.pop_front();
      checkOutput("resultRDY", bus.data_resultRDY, 1);
      if (bus.data_resultRDY) begin
        checkOutput("exception", bus.data_exception, x.exc);
        checkOutput("op_div", bus.op_div, x.opDiv);
      end
    end else begin
      checkOutput("spuriousRDY", bus.data_resultRDY, 0);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic d, input logic z,
                               input logic o, input logic c);
    bus.ctrl_MULT    = m;
    bus.ctrl_DIV     = d;
    bus.divisor_zero = z;
    bus.mult_ovf     = o;
    clr              = c;
    @(negedge clk);
    scoreboardCheck();
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int base;
    vecs[0] = mkVec("mult",       1, 0, 0, 0, 16, -1, 17, 0, 0);
    vecs[1] = mkVec("div",        0, 1, 0, 0, 32, 33, 34, 0, 1);
    vecs[2] = mkVec("divByZero",  0, 1, 1, 0,  0, -1,  1, 1, 1);
    vecs[3] = mkVec("multOvf",    1, 0, 0, 1, 16, -1, 17, 1, 0);
    vecs[4] = mkVec("bothStart",  1, 1, 0, 0, 16, -1, 17, 0, 0);
    vecs[5] = mkVec("bothDz",     1, 1, 1, 0, 16, -1, 17, 0, 0);
    vecs[6] = mkVec("multDz",     1, 0, 1, 0, 16, -1, 17, 0, 0);
    vecs[7] = mkVec("divOvf",     0, 1, 0, 1, 32, 33, 34, 0, 1);

    // Reset with a start request held: everything must stay quiet.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, 0, 1);
      checkOutput("resetOutputs", allOutputs(), 0);
      endCycle();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("idleOutputs", allOutputs(), 0);
    endCycle();

    for (int v = 0; v < 8; v++) begin
      curName = vecs[v].name;
      base = cyc;
      pushExpect(base + vecs[v].rdyCycle, vecs[v].expExc, vecs[v].expOpDiv);
      for (int k = 0; k <= vecs[v].rdyCycle + 2; k++) begin
        if (k == 0) applyStimulus(vecs[v].isMult, vecs[v].isDiv, vecs[v].dz, vecs[v].ovf, 0);
        else        applyStimulus(0, 0, ~vecs[v].dz, vecs[v].ovf, 0);
        checkOutput("load_en", bus.load_en, k == 0);
        checkOutput("step_en", bus.step_en, k >= 1 && k <= vecs[v].steps);
        checkOutput("fix_en", bus.fix_en, k == vecs[v].fixCycle);
        checkOutput("busy", bus.busy, k <= vecs[v].rdyCycle);
        if (k >= 1 && k <= vecs[v].steps) checkOutput("iter_count", bus.iter_count, k - 1);
        endCycle();
      end
    end

    // Multiply aborted by a divide at cycle 5; only the divide completes.
    curName = "abort";
    base = cyc;
    pushExpect(base + 39, 0, 1);
    for (int k = 0; k <= 41; k++) begin
      applyStimulus(k == 0, k == 5, 0, 0, 0);
      checkOutput("load_en", bus.load_en, k == 0 || k == 5);
      checkOutput("fix_en", bus.fix_en, k == 38);
      if (k >= 6 && k <= 37) checkOutput("step_en", bus.step_en, 1);
      if (k == 6) checkOutput("iter_count", bus.iter_count, 0);
      endCycle();
    end

    // clr in cycle 10 of a divide: no result ever appears.
    curName = "resetMidRun";
    for (int k = 0; k <= 40; k++) begin
      applyStimulus(0, k == 0, 0, 0, k == 10);
      if (k >= 11) checkOutput("outputsAfterClr", allOutputs(), 0);
      endCycle();
    end

    // Start in the cycle after DONE is taken normally.
    curName = "backToBack";
    base = cyc;
    pushExpect(base + 17, 0, 0);
    pushExpect(base + 35, 1, 0);
    for (int k = 0; k <= 37; k++) begin
      applyStimulus(k == 0 || k == 18, 0, 0, k >= 18, 0);
      checkOutput("load_en", bus.load_en, k == 0 || k == 18);
      endCycle();
    end

    // Start during DONE: that DONE still reports, then the new divide runs.
    curName = "restartInDone";
    base = cyc;
    pushExpect(base + 17, 0, 0);
    pushExpect(base + 51, 0, 1);
    for (int k = 0; k <= 53; k++) begin
      applyStimulus(k == 0, k == 17, 0, 0, 0);
      checkOutput("load_en", bus.load_en, k == 0 || k == 17);
      if (k >= 18 && k <= 49) checkOutput("step_en", bus.step_en, 1);
      checkOutput("fix_en", bus.fix_en, k == 50);
      endCycle();
    end

    curName = "drain";
    checkOutput("pendingResults", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
